// File: rtl/io_isolate_pipe_if.sv
// Core-to-pad peripheral write bus seen by io_isolate_pipe: core request side plus
// registered pad side. The pipe uses the master modport, the surrounding logic the slave.
interface io_isolate_pipe_if #(
   parameter int unsigned PA_W = 16,
   parameter int unsigned PD_W = 16
) ();

   logic            core_peri_web;
   logic [PA_W-1:0] core_peri_addr;
   logic [PD_W-1:0] core_peri_datao;
   logic            core_peri_stall;
   logic            peri_ready;
   logic            peri_web;
   logic [PA_W-1:0] peri_addr;
   logic [PD_W-1:0] peri_datao;
   logic            peri_ovf;

   modport master (
      input  core_peri_web, core_peri_addr, core_peri_datao, peri_ready,
      output core_peri_stall, peri_web, peri_addr, peri_datao, peri_ovf
   );

   modport slave (
      output core_peri_web, core_peri_addr, core_peri_datao, peri_ready,
      input  core_peri_stall, peri_web, peri_addr, peri_datao, peri_ovf
   );

endinterface

// File: rtl/io_isolate_pipe.sv
// IO isolation pipe: boot bus delay line, core reset synchroniser and a peripheral write FIFO.
// Define IO_PIPE_WCNT_EN to add the 16-bit peri_wr_cnt pop counter output.
module io_isolate_pipe #(
   parameter int unsigned IN_DEPTH   = 1,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned BA_W       = 8,
   parameter int unsigned BD_W       = 32,
   parameter int unsigned PA_W       = 16,
   parameter int unsigned PD_W       = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            boot_up,
   input  logic            boot_web,
   input  logic [BA_W-1:0] boot_addr,
   input  logic [BD_W-1:0] boot_datai,
   output logic            core_rst_n,
   output logic            core_boot_up,
   output logic            core_boot_web,
   output logic [BA_W-1:0] core_boot_addr,
   output logic [BD_W-1:0] core_boot_datai,
`ifdef IO_PIPE_WCNT_EN
   output logic [15:0]     peri_wr_cnt,
`endif
   io_isolate_pipe_if.master peri
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned DW = PA_W + PD_W;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   // ---------------- core reset synchroniser ----------------
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= 2'b00;
      else        sync_q <= {sync_q[0], 1'b1};
   end

   assign core_rst_n = sync_q[1];

   // ---------------- boot delay line ----------------
   logic [IN_DEPTH-1:0] up_q;
   logic [IN_DEPTH-1:0] web_q;
   logic [BA_W-1:0]     baddr_q [IN_DEPTH];
   logic [BD_W-1:0]     bdata_q [IN_DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         up_q  <= '0;
         web_q <= '1;
         for (int i = 0; i < int'(IN_DEPTH); i++) begin
            baddr_q[i] <= '0;
            bdata_q[i] <= '0;
         end
      end else begin
         up_q[0]    <= boot_up;
         web_q[0]   <= boot_web;
         baddr_q[0] <= boot_addr;
         bdata_q[0] <= boot_datai;
         for (int i = 1; i < int'(IN_DEPTH); i++) begin
            up_q[i]    <= up_q[i-1];
            web_q[i]   <= web_q[i-1];
            baddr_q[i] <= baddr_q[i-1];
            bdata_q[i] <= bdata_q[i-1];
         end
      end
   end

   assign core_boot_up    = up_q[IN_DEPTH-1];
   assign core_boot_web   = web_q[IN_DEPTH-1];
   assign core_boot_addr  = baddr_q[IN_DEPTH-1];
   assign core_boot_datai = bdata_q[IN_DEPTH-1];

   // ---------------- peripheral write FIFO ----------------
   logic [DW-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [CW-1:0]   cnt_q;
   logic            full, push, pop, drop;
   logic [DW-1:0]   head;
   logic            pw_q, ovf_q;
   logic [PA_W-1:0] pa_q;
   logic [PD_W-1:0] pd_q;

   // Full decoded from the registered count only, so stall never depends on this cycle's request.
   assign full = (cnt_q == FULL_CNT);
   assign push = !peri.core_peri_web && !full;
   assign drop = !peri.core_peri_web && full;
   assign pop  = (cnt_q != '0) && peri.peri_ready;
   assign head = mem_q[rptr_q];

   // Payload storage carries no reset; validity is tracked by the count alone.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= {peri.core_peri_addr, peri.core_peri_datao};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         pw_q   <= 1'b1;
         pa_q   <= '0;
         pd_q   <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         if (push && !pop)      cnt_q <= cnt_q + CW'(1);
         else if (pop && !push) cnt_q <= cnt_q - CW'(1);
         if (drop) ovf_q <= 1'b1;
         pw_q <= !pop;
         if (pop) begin
            pa_q <= head[DW-1:PD_W];
            pd_q <= head[PD_W-1:0];
         end
      end
   end

   assign peri.core_peri_stall = full;
   assign peri.peri_web        = pw_q;
   assign peri.peri_addr       = pa_q;
   assign peri.peri_datao      = pd_q;
   assign peri.peri_ovf        = ovf_q;

`ifdef IO_PIPE_WCNT_EN
   logic [15:0] wcnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   wcnt_q <= '0;
      else if (pop) wcnt_q <= wcnt_q + 16'd1;
   end

   assign peri_wr_cnt = wcnt_q;
`endif

endmodule

// File: tb/tb_io_isolate_pipe.sv
// Directed self-checking bench for io_isolate_pipe (IN_DEPTH=3, FIFO_DEPTH=4).
module tb_io_isolate_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        boot_up, boot_web;
   logic [7:0]  boot_addr;
   logic [31:0] boot_datai;
   logic        core_rst_n, core_boot_up, core_boot_web;
   logic [7:0]  core_boot_addr;
   logic [31:0] core_boot_datai;
`ifdef IO_PIPE_WCNT_EN
   logic [15:0] peri_wr_cnt;
`endif

   int unsigned n_err = 0;
   int unsigned n_chk = 0;

   io_isolate_pipe_if #(.PA_W(16), .PD_W(16)) bus ();

   io_isolate_pipe #(
      .IN_DEPTH(3), .FIFO_DEPTH(4), .BA_W(8), .BD_W(32), .PA_W(16), .PD_W(16)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .boot_up         (boot_up),
      .boot_web        (boot_web),
      .boot_addr       (boot_addr),
      .boot_datai      (boot_datai),
      .core_rst_n      (core_rst_n),
      .core_boot_up    (core_boot_up),
      .core_boot_web   (core_boot_web),
      .core_boot_addr  (core_boot_addr),
      .core_boot_datai (core_boot_datai),
`ifdef IO_PIPE_WCNT_EN
      .peri_wr_cnt     (peri_wr_cnt),
`endif
      .peri            (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      boot_up = 1'b0; boot_web = 1'b1; boot_addr = '0; boot_datai = '0;
      bus.core_peri_web = 1'b1; bus.core_peri_addr = '0; bus.core_peri_datao = '0;
      bus.peri_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst core_rst_n", core_rst_n, 0);
      check("rst peri_web", bus.peri_web, 1);
      check("rst peri_addr", bus.peri_addr, 0);
      check("rst peri_datao", bus.peri_datao, 0);
      check("rst peri_ovf", bus.peri_ovf, 0);
      check("rst stall", bus.core_peri_stall, 0);
      check("rst boot_web", core_boot_web, 1);
      check("rst boot_up", core_boot_up, 0);
      check("rst boot_addr", core_boot_addr, 0);

      // Reset release between edges: two edges to deassert core_rst_n
      repeat (2) step();
      rst_n = 1'b1;
      step();
      check("sync edge1", core_rst_n, 0);
      step();
      check("sync edge2", core_rst_n, 1);

      // Boot path, 3-stage delay
      boot_addr = 8'h5A; boot_web = 1'b0; boot_up = 1'b1; boot_datai = 32'hCAFEF00D;
      step();
      boot_addr = 8'h11; boot_web = 1'b1; boot_up = 1'b0; boot_datai = 32'h0;
      step();
      check("boot t+2 addr", core_boot_addr, 8'h00);
      check("boot t+2 web", core_boot_web, 1);
      step();
      check("boot t+3 addr", core_boot_addr, 8'h5A);
      check("boot t+3 web", core_boot_web, 0);
      check("boot t+3 up", core_boot_up, 1);
      check("boot t+3 data", core_boot_datai, 32'hCAFEF00D);
      step();
      check("boot t+4 addr", core_boot_addr, 8'h11);
      check("boot t+4 web", core_boot_web, 1);

      // Single write, two-edge latency, one-cycle strobe
      bus.peri_ready = 1'b1;
      bus.core_peri_web = 1'b0; bus.core_peri_addr = 16'h1234; bus.core_peri_datao = 16'hBEEF;
      step();
      bus.core_peri_web = 1'b1;
      check("single t web", bus.peri_web, 1);
      step();
      check("single t+1 web", bus.peri_web, 0);
      check("single addr", bus.peri_addr, 16'h1234);
      check("single data", bus.peri_datao, 16'hBEEF);
      step();
      check("single t+2 web", bus.peri_web, 1);
      check("single hold addr", bus.peri_addr, 16'h1234);

      // Fill to full with sink stalled, fifth write dropped
      bus.peri_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.core_peri_web = 1'b0;
         bus.core_peri_addr = 16'h0100 + 16'(i);
         bus.core_peri_datao = 16'hA000 + 16'(i);
         step();
         if (i == 2) check("fill stall@3", bus.core_peri_stall, 0);
         if (i == 3) begin
            check("fill stall@4", bus.core_peri_stall, 1);
            check("fill ovf@4", bus.peri_ovf, 0);
         end
         if (i == 4) begin
            check("fill stall@5", bus.core_peri_stall, 1);
            check("fill ovf@5", bus.peri_ovf, 1);
         end
      end
      bus.core_peri_web = 1'b1;
      step();
      check("hold no pop", bus.peri_web, 1);
      bus.peri_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("drain web", bus.peri_web, 0);
         check("drain addr", bus.peri_addr, 16'h0100 + 16'(i));
         check("drain data", bus.peri_datao, 16'hA000 + 16'(i));
         if (i == 0) check("drain stall", bus.core_peri_stall, 0);
      end
      step();
      check("no fifth pop", bus.peri_web, 1);
      check("ovf sticky", bus.peri_ovf, 1);

      // Steady push+pop at count 2 for 20 cycles
      bus.peri_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.core_peri_web = 1'b0;
         bus.core_peri_addr = 16'h0200 + 16'(i);
         bus.core_peri_datao = 16'hB000 + 16'(i);
         step();
      end
      bus.peri_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         bus.core_peri_web = 1'b0;
         bus.core_peri_addr = 16'h0202 + 16'(k);
         bus.core_peri_datao = 16'hB002 + 16'(k);
         step();
         check("stream web", bus.peri_web, 0);
         check("stream addr", bus.peri_addr, 16'h0200 + 16'(k));
         check("stream data", bus.peri_datao, 16'hB000 + 16'(k));
         check("stream stall", bus.core_peri_stall, 0);
      end
      bus.core_peri_web = 1'b1;
      step();
      check("tail1 addr", bus.peri_addr, 16'h0214);
      step();
      check("tail2 addr", bus.peri_addr, 16'h0215);
      check("tail2 web", bus.peri_web, 0);
      step();
      check("tail empty", bus.peri_web, 1);

      // Mid-operation reset discards buffered entries
      bus.peri_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.core_peri_web = 1'b0;
         bus.core_peri_addr = 16'h0300 + 16'(i);
         step();
      end
      bus.core_peri_web = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("midrst core_rst_n", core_rst_n, 0);
      check("midrst web", bus.peri_web, 1);
      check("midrst ovf", bus.peri_ovf, 0);
      check("midrst addr", bus.peri_addr, 0);
      step();
      rst_n = 1'b1;
      bus.peri_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("midrst no write", bus.peri_web, 1);
      end
      check("midrst resync", core_rst_n, 1);

`ifdef IO_PIPE_WCNT_EN
      check("cnt reset", peri_wr_cnt, 0);
      bus.core_peri_web = 1'b0;
      // First edge only pushes; each later edge pops once
      repeat (32'h10000) step();
      check("cnt ffff", peri_wr_cnt, 16'hFFFF);
      step();
      check("cnt wrap", peri_wr_cnt, 16'h0000);
      step();
      check("cnt one", peri_wr_cnt, 16'h0001);
      #2 rst_n = 1'b0;
      #1;
      check("cnt midrst", peri_wr_cnt, 0);
      check("cnt midrst web", bus.peri_web, 1);
      check("cnt midrst stall", bus.core_peri_stall, 0);
      bus.core_peri_web = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      check("cnt post rst", peri_wr_cnt, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
